// File: rtl/adder_pipe_retry_ctrl_pkg.sv
// ============================================================================
// Module : adder_ctrl_pkg
// Shared state encoding, default sizing and a width helper for the
// adder pipeline retry controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_ctrl_pkg;

  localparam int C_WORD_WIDTH = 4;
  localparam int C_LAYERS     = 1;
  localparam int C_MAX_RETRY  = 2;
  localparam int C_CNT_W      = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_pipe_retry_ctrl_if.sv
// ============================================================================
// Module : adder_pipe_retry_ctrl_if
// Requester, datapath and consumer signals of the retry controller.
// Optional alarm log ports exist only when ALARM_LOG_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_pipe_retry_ctrl_if #(
  parameter int WORD_WIDTH = adder_ctrl_pkg::C_WORD_WIDTH,
  parameter int LAYERS     = adder_ctrl_pkg::C_LAYERS,
  parameter int CNT_W      = adder_ctrl_pkg::C_CNT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  pipe_en;
  logic [WORD_WIDTH-1:0] pipe_in;
  logic [WORD_WIDTH-1:0] pipe_sum;
  logic [LAYERS-1:0]     alarm_signals;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_error;
  logic [CNT_W-1:0]      err_count;
  logic                  busy;
`ifdef ALARM_LOG_EN
  logic [LAYERS-1:0]     alarm_log;
  logic                  alarm_log_clr;
`endif

  modport master (
    input  in_valid, in_data, pipe_sum, alarm_signals, out_ready,
`ifdef ALARM_LOG_EN
    input  alarm_log_clr,
    output alarm_log,
`endif
    output in_ready, pipe_en, pipe_in, out_valid, out_data, out_error,
    output err_count, busy
  );

  modport slave (
    output in_valid, in_data, pipe_sum, alarm_signals, out_ready,
`ifdef ALARM_LOG_EN
    output alarm_log_clr,
    input  alarm_log,
`endif
    input  in_ready, pipe_en, pipe_in, out_valid, out_data, out_error,
    input  err_count, busy
  );

endinterface

`default_nettype wire

// File: rtl/adder_pipe_retry_ctrl_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_inc,
  output logic      [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/adder_pipe_retry_ctrl.sv
// ============================================================================
// Module : adder_pipe_retry_ctrl
// Sequences one operand through the cascaded adder pipeline, replaying it on
// stage alarms. Optional alarm history register: ALARM_LOG_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_pipe_retry_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = C_WORD_WIDTH,
  parameter int LAYERS     = C_LAYERS,
  parameter int MAX_RETRY  = C_MAX_RETRY,
  parameter int CNT_W      = C_CNT_W
) (
  input  wire logic               clk,
  input  wire logic               rst,
  adder_pipe_retry_ctrl_if.master bus
);

  localparam int RW = cnt_width(MAX_RETRY + 1);
  localparam int SW = cnt_width(LAYERS);
  localparam logic [RW-1:0] C_RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [SW-1:0] C_STAGE_LAST = SW'(LAYERS - 1);

  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_hold;
  logic [WORD_WIDTH-1:0] r_out_data;
  logic                  r_out_error;
  logic [RW-1:0]         r_retry;
  logic [SW-1:0]         r_stage;
  logic                  w_alarm;
  logic                  w_err_inc;

  assign w_alarm   = |bus.alarm_signals;
  assign w_err_inc = (r_state == ST_CHECK) && w_alarm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_error <= 1'b0;
      r_retry     <= '0;
      r_stage     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_hold  <= bus.in_data;
            r_retry <= '0;
            r_stage <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Operand is held on pipe_in for one enable per stage so the
          // whole cascade settles on the same word.
          if (r_stage == C_STAGE_LAST) begin
            r_stage <= '0;
            r_state <= ST_CHECK;
          end else begin
            r_stage <= r_stage + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!w_alarm) begin
            r_out_data  <= bus.pipe_sum;
            r_out_error <= 1'b0;
            r_state     <= ST_DONE;
          end else if (r_retry < C_RETRY_MAX) begin
            r_retry <= r_retry + 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_out_data  <= bus.pipe_sum;
            r_out_error <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_err_inc),
    .o_count (bus.err_count)
  );

`ifdef ALARM_LOG_EN
  logic [LAYERS-1:0] r_alarm_log;

  // Clear wins over a same-cycle accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm_log <= '0;
    end else if (bus.alarm_log_clr) begin
      r_alarm_log <= '0;
    end else if (r_state == ST_CHECK) begin
      r_alarm_log <= r_alarm_log | bus.alarm_signals;
    end
  end

  assign bus.alarm_log = r_alarm_log;
`endif

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.pipe_en   = (r_state == ST_RUN);
  assign bus.pipe_in   = r_hold;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_out_data;
  assign bus.out_error = r_out_error;

endmodule

`default_nettype wire

// File: tb/tb_adder_pipe_retry_ctrl.sv
// ============================================================================
// Module : tb_adder_pipe_retry_ctrl
// Randomised bench with a behavioural datapath and expected-result model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_pipe_retry_ctrl;

  localparam int W  = 4;
  localparam int L  = 1;
  localparam int MR = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_pipe_retry_ctrl_if #(.WORD_WIDTH(W), .LAYERS(L), .CNT_W(CW)) bus ();

  adder_pipe_retry_ctrl #(
    .WORD_WIDTH (W),
    .LAYERS     (L),
    .MAX_RETRY  (MR),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Datapath stand-in: every stage doubles its input while enabled.
  logic [W-1:0]   stg [L];
  logic [L-1:0]   plan [MR+1];
  logic [L-1:0]   noise;
  int             en_cnt;

  always @(posedge clk) begin
    if (bus.pipe_en) begin
      stg[0] <= bus.pipe_in + bus.pipe_in;
      for (int i = 1; i < L; i++) stg[i] <= stg[i-1] + stg[i-1];
    end
  end
  assign bus.pipe_sum = stg[L-1];

  always @(posedge clk or posedge rst) begin
    if (rst) en_cnt <= 0;
    else if (bus.in_valid && bus.in_ready) en_cnt <= 0;
    else if (bus.pipe_en) en_cnt <= en_cnt + 1;
  end

  always @(negedge clk) noise <= L'($urandom);

  // Alarm pattern per attempt; random junk while the pipeline is running.
  always_comb begin
    int idx;
    idx = (en_cnt / L) - 1;
    if (idx > MR) idx = MR;
    bus.alarm_signals = noise;
    if (!bus.pipe_en && en_cnt > 0) bus.alarm_signals = plan[idx];
  end

  int err_model = 0;

  task automatic do_op(input logic [W-1:0] d, input int bp);
    int first_clean, alarms, attempts, lat, n;
    logic exp_err;
    logic [W-1:0] exp_data;
    first_clean = -1;
    for (int i = 0; i <= MR; i++)
      if (first_clean < 0 && plan[i] == '0) first_clean = i;
    exp_err  = (first_clean < 0);
    alarms   = exp_err ? MR + 1 : first_clean;
    attempts = exp_err ? MR + 1 : first_clean + 1;
    lat      = L + 2 + (attempts - 1) * (L + 1);
    exp_data = W'(int'(d) * (1 << L));
    err_model = err_model + alarms;
    if (err_model > (1 << CW) - 1) err_model = (1 << CW) - 1;

    check_eq("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_eq("pipe_en_run", bus.pipe_en, 1'b1);
    check_eq("pipe_in", bus.pipe_in, d);
    n = 1;
    while (!bus.out_valid && n < 200) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = W'($urandom);
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, lat);
    check_eq("out_data", bus.out_data, exp_data);
    check_eq("out_error", bus.out_error, exp_err);
    check_eq("err_count", bus.err_count, err_model);
    for (int k = 0; k < bp; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      @(negedge clk);
      check_eq("bp_valid", bus.out_valid, 1'b1);
      check_eq("bp_data", bus.out_data, exp_data);
      check_eq("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("valid_drop", bus.out_valid, 1'b0);
    check_eq("in_ready_back", bus.in_ready, 1'b1);
    check_eq("busy_clear", bus.busy, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check_eq({tag, "_pipe_en"}, bus.pipe_en, 1'b0);
    check_eq({tag, "_pipe_in"}, bus.pipe_in, '0);
    check_eq({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_out_data"}, bus.out_data, '0);
    check_eq({tag, "_out_error"}, bus.out_error, 1'b0);
    check_eq({tag, "_err_count"}, bus.err_count, '0);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef ALARM_LOG_EN
    bus.alarm_log_clr = 1'b0;
`endif
    for (int i = 0; i <= MR; i++) plan[i] = '0;
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Clean, single-alarm, then persistent alarm (saturates the 2-bit count).
    do_op(4'h3, 4);
    plan[0] = '1;
    do_op(4'h5, 2);
    for (int i = 0; i <= MR; i++) plan[i] = '1;
    do_op(4'h7, 3);
    do_op(4'h2, 0);

    // Mid-operation reset, then a normal operand.
    for (int i = 0; i <= MR; i++) plan[i] = '0;
    bus.in_data  = 4'h9;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    err_model = 0;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_eq("no_valid_after_rst", seen, 0);
    do_op(4'h4, 1);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i <= MR; i++)
        plan[i] = ($urandom_range(0, 2) == 0) ? L'($urandom_range(1, (1 << L) - 1)) : '0;
      do_op(W'($urandom), $urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
